// File: rtl/cmac_array.sv
// cmac_array -- multi-lane multiply-accumulate engine for convolution layers.
//
// One activation stream is broadcast to LANES lanes. Each lane multiplies it
// by its own weight stream and accumulates over cfg_len beats, starting from
// its bias (aligned to the product's binary point). When the kernel finishes,
// each lane rounds half-up back to Q(DATA_W-FRAC).FRAC, saturates, and
// optionally clamps negatives to zero (ReLU).
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   start              pulse in IDLE: latch cfg_len/cfg_relu, load bias, begin
//   cfg_len, cfg_relu  kernel length (0 allowed) and ReLU enable
//   in_bias            per-lane bias, lane i at [i*DATA_W +: DATA_W]
//   busy               high from accepted start until the result is taken
//   in_valid/in_ready  beat handshake for in_data (broadcast) and in_weight
//   out_valid/out_ready result handshake; out_data held while stalled
//   out_data           per-lane result, lane i at [i*DATA_W +: DATA_W]
module cmac_array #(
  parameter int LANES  = 4,
  parameter int DATA_W = 16,
  parameter int FRAC   = 8,
  parameter int ACC_W  = 40,
  parameter int LEN_W  = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        cfg_len,
  input  logic                    cfg_relu,
  input  logic [LANES*DATA_W-1:0] in_bias,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [LANES*DATA_W-1:0] in_weight,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_OUT} state_t;

  // Rounding constant 2^(FRAC-1) and saturation bounds, one bit wider than
  // the accumulator so the rounding add can never wrap.
  localparam logic signed [ACC_W:0] HALF =
    {{(ACC_W+1-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((1 << (DATA_W-1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = -SAT_MAX - 1;

  state_t                  state_reg;
  logic [LEN_W-1:0]        len_reg;
  logic [LEN_W-1:0]        cnt_reg;
  logic                    relu_reg;
  logic [1:0]              drain_reg;
  logic                    prod_valid_reg;
  logic                    out_valid_reg;
  logic [LANES*DATA_W-1:0] out_data_reg;
  logic [LANES*DATA_W-1:0] result_next;
  logic                    beat_xfer;
  logic                    start_accept;

  assign in_ready     = (state_reg == S_ACCUM) && (cnt_reg < len_reg);
  assign beat_xfer    = in_valid && in_ready;
  assign start_accept = (state_reg == S_IDLE) && start;
  assign busy         = (state_reg != S_IDLE);
  assign out_valid    = out_valid_reg;
  assign out_data     = out_data_reg;

  // Control FSM. The drain counter holds the number of extra DRAIN cycles:
  // after the last beat, one ACCUM cycle plus two DRAIN cycles let the
  // product and accumulate stages settle. A zero-length kernel skips ACCUM,
  // so it spends one more cycle in DRAIN to keep out_valid at the same
  // three-cycle distance from start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      len_reg        <= '0;
      cnt_reg        <= '0;
      relu_reg       <= 1'b0;
      drain_reg      <= '0;
      prod_valid_reg <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
    end else begin
      prod_valid_reg <= beat_xfer;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            len_reg  <= cfg_len;
            relu_reg <= cfg_relu;
            cnt_reg  <= '0;
            if (cfg_len == '0) begin
              state_reg <= S_DRAIN;
              drain_reg <= 2'd2;
            end else begin
              state_reg <= S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          if (beat_xfer) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
          if (cnt_reg == len_reg) begin
            state_reg <= S_DRAIN;
            drain_reg <= 2'd1;
          end
        end
        S_DRAIN: begin
          if (drain_reg == 2'd0) begin
            state_reg     <= S_OUT;
            out_valid_reg <= 1'b1;
            out_data_reg  <= result_next;
          end else begin
            drain_reg <= drain_reg - 2'd1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            state_reg     <= S_IDLE;
            out_valid_reg <= 1'b0;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [DATA_W-1:0]   data_s;
    logic signed [DATA_W-1:0]   weight_s;
    logic signed [ACC_W-1:0]    bias_ext;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [2*DATA_W-1:0] prod_reg;
    logic signed [ACC_W-1:0]    acc_reg;
    logic signed [ACC_W:0]      acc_wide;
    logic signed [ACC_W:0]      sum_wide;
    logic signed [ACC_W:0]      shifted;
    logic [DATA_W-1:0]          lane_res;

    assign data_s   = in_data;
    assign weight_s = in_weight[gi*DATA_W +: DATA_W];
    assign bias_ext = {{(ACC_W-DATA_W){in_bias[gi*DATA_W+DATA_W-1]}},
                       in_bias[gi*DATA_W +: DATA_W]};
    assign prod_ext = {{(ACC_W-2*DATA_W){prod_reg[2*DATA_W-1]}}, prod_reg};

    // Stage 1: product register; stage 2: accumulate (wraps at ACC_W bits).
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        prod_reg <= '0;
        acc_reg  <= '0;
      end else begin
        if (beat_xfer) begin
          prod_reg <= data_s * weight_s;
        end
        if (start_accept) begin
          acc_reg <= bias_ext <<< FRAC;
        end else if (prod_valid_reg) begin
          acc_reg <= acc_reg + prod_ext;
        end
      end
    end

    // Round half up, arithmetic shift back to FRAC bits, saturate, ReLU.
    assign acc_wide = {acc_reg[ACC_W-1], acc_reg};
    assign sum_wide = acc_wide + HALF;
    assign shifted  = sum_wide >>> FRAC;

    always_comb begin
      lane_res = shifted[DATA_W-1:0];
      if (shifted > SAT_MAX) begin
        lane_res = SAT_MAX[DATA_W-1:0];
      end else if (shifted < SAT_MIN) begin
        lane_res = SAT_MIN[DATA_W-1:0];
      end
      if (relu_reg && shifted[ACC_W]) begin
        lane_res = '0;
      end
    end

    assign result_next[gi*DATA_W +: DATA_W] = lane_res;
  end

endmodule

// File: tb/tb_cmac_array.sv
// tb_cmac_array -- self-checking bench for cmac_array.
// A behavioural model (plain 64-bit arithmetic over the beat tables) predicts
// each kernel's result; a negedge monitor compares out_data against it every
// cycle out_valid is high. Directed kernels also pin literal results.
module tb_cmac_array;
  localparam int LANES  = 4;
  localparam int DATA_W = 16;
  localparam int FRAC   = 8;
  localparam int ACC_W  = 40;
  localparam int LEN_W  = 12;
  localparam int VW     = LANES * DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  cfg_len;
  logic              cfg_relu;
  logic [VW-1:0]     in_bias;
  logic              busy;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [VW-1:0]     in_weight;
  logic              out_valid;
  logic              out_ready;
  logic [VW-1:0]     out_data;

  cmac_array #(
    .LANES(LANES), .DATA_W(DATA_W), .FRAC(FRAC), .ACC_W(ACC_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_relu(cfg_relu),
    .in_bias(in_bias), .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_weight(in_weight), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DATA_W-1:0] beat_data [16];
  logic [DATA_W-1:0] beat_w    [16][LANES];
  logic [VW-1:0]     exp_q[$];
  logic [VW-1:0]     last_out;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Result of a kernel from first principles: bias scaled to the product's
  // binary point, plus the exact dot product, then round/saturate/ReLU.
  function automatic logic [VW-1:0] model(input int len, input bit relu, input logic [VW-1:0] bias);
    logic [VW-1:0] res;
    longint acc;
    longint r;
    longint maxv;
    res  = '0;
    maxv = (longint'(1) << (DATA_W-1)) - 1;
    for (int l = 0; l < LANES; l++) begin
      acc = longint'($signed(bias[l*DATA_W +: DATA_W])) * (longint'(1) << FRAC);
      for (int b = 0; b < len; b++)
        acc += longint'($signed(beat_data[b])) * longint'($signed(beat_w[b][l]));
      r = (acc + (longint'(1) << (FRAC-1))) >>> FRAC;
      if (r > maxv) r = maxv;
      if (r < -maxv - 1) r = -maxv - 1;
      if (relu && r < 0) r = 0;
      res[l*DATA_W +: DATA_W] = r[DATA_W-1:0];
    end
    return res;
  endfunction

  // Compare process: every cycle out_valid is high, out_data must equal the
  // pending expectation (this also covers stability under back-pressure).
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", VW'(out_valid), VW'(0));
      end else begin
        check("out_data", out_data, exp_q[0]);
        if (out_ready) begin
          last_out = out_data;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic fill_const(input int len, input logic [DATA_W-1:0] d, input logic [VW-1:0] w);
    for (int b = 0; b < len; b++) begin
      beat_data[b] = d;
      for (int l = 0; l < LANES; l++) beat_w[b][l] = w[l*DATA_W +: DATA_W];
    end
  endtask

  // gaps: 0 = back-to-back, 1 = alternate 1010..., 2 = random
  // poke: pulse start (with different cfg/bias) during ACCUM and during OUT
  task automatic run_kernel(input int len, input bit relu, input logic [VW-1:0] bias,
                            input int gaps, input int stall, input bit poke);
    int beat = 0;
    int guard = 0;
    int last_cyc;
    int rise_cyc = 0;
    bit xfer;
    bit seen = 0;
    bit ready_seen = 0;
    exp_q.push_back(model(len, relu, bias));
    out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; cfg_len = LEN_W'(len); cfg_relu = relu; in_bias = bias;
    @(posedge clk); #1;
    start = 1'b0;
    last_cyc = cyc;
    // Scramble configuration inputs: the engine must have latched them.
    cfg_len = LEN_W'($urandom); cfg_relu = ~relu; in_bias = {$urandom, $urandom};
    while (beat < len && guard < 200) begin
      case (gaps)
        0:       in_valid = 1'b1;
        1:       in_valid = (guard % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = beat_data[beat];
      for (int l = 0; l < LANES; l++) in_weight[l*DATA_W +: DATA_W] = beat_w[beat][l];
      if (poke && guard == 1) begin
        start = 1'b1; cfg_len = LEN_W'(3); in_bias = '1;
      end
      @(negedge clk);
      xfer = in_valid && in_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (xfer) begin
        beat++;
        last_cyc = cyc;
      end
      guard++;
    end
    in_valid = 1'b0;
    in_data = DATA_W'($urandom);
    if (beat < len) check("beat_timeout", VW'(beat), VW'(len));
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (in_ready) ready_seen = 1'b1;
      if (out_valid) begin
        seen = 1'b1;
        rise_cyc = cyc;
      end
    end
    check("out_valid_seen", VW'(seen), VW'(1));
    if (seen) check("latency", VW'(rise_cyc - last_cyc), VW'(3));
    if (len == 0) check("len0_in_ready_low", VW'(ready_seen), VW'(0));
    @(posedge clk); #1;
    for (int k = 0; k < stall; k++) begin
      start = poke && (k == 2);
      cfg_len = '0;
      @(posedge clk); #1;
      start = 1'b0;
      check("hold_valid", VW'(out_valid), VW'(1));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("busy_after_take", VW'(busy), VW'(0));
    check("valid_after_take", VW'(out_valid), VW'(0));
    check("queue_drained", VW'(exp_q.size()), VW'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; cfg_len = '0; cfg_relu = 1'b0; in_bias = '0;
    in_valid = 1'b0; in_data = '0; in_weight = '0; out_ready = 1'b0;
    #1;
    check("reset_out_valid", VW'(out_valid), VW'(0));
    check("reset_out_data", out_data, VW'(0));
    check("reset_busy", VW'(busy), VW'(0));
    check("reset_in_ready", VW'(in_ready), VW'(0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // T1: basic dot product
    fill_const(3, 16'h0100, {16'h0000, 16'hFF00, 16'h0200, 16'h0100});
    run_kernel(3, 1'b0, '0, 0, 0, 1'b0);
    check("T1_literal", last_out, {16'h0000, 16'hFD00, 16'h0600, 16'h0300});

    // T2: saturation both ways, then ReLU
    fill_const(4, 16'h7FFF, {16'h0000, 16'h0000, 16'h8001, 16'h7FFF});
    run_kernel(4, 1'b0, '0, 0, 0, 1'b0);
    check("T2_literal", last_out, {16'h0000, 16'h0000, 16'h8000, 16'h7FFF});
    run_kernel(4, 1'b1, '0, 0, 1, 1'b0);
    check("T2_relu_literal", last_out, {16'h0000, 16'h0000, 16'h0000, 16'h7FFF});

    // T3: zero-length kernel passes bias through
    run_kernel(0, 1'b0, {16'h7FFF, 16'h0000, 16'hFF80, 16'h0080}, 0, 0, 1'b0);
    check("T3_literal", last_out, {16'h7FFF, 16'h0000, 16'hFF80, 16'h0080});

    // T4: gapped input, long stall, ignored start pulses
    fill_const(5, 16'h0200, {4{16'h0100}});
    run_kernel(5, 1'b0, '0, 1, 6, 1'b1);
    check("T4_literal", last_out, {4{16'h0A00}});

    // T5: reset in the middle of accumulation
    fill_const(5, 16'h0300, {4{16'h0200}});
    @(posedge clk); #1;
    start = 1'b1; cfg_len = LEN_W'(5); cfg_relu = 1'b0; in_bias = {4{16'h0100}};
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = beat_data[0]; in_weight = {4{16'h0200}};
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("T5_rst_out_valid", VW'(out_valid), VW'(0));
    check("T5_rst_out_data", out_data, VW'(0));
    check("T5_rst_busy", VW'(busy), VW'(0));
    check("T5_rst_in_ready", VW'(in_ready), VW'(0));
    in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    fill_const(1, 16'h0100, {4{16'h0100}});
    run_kernel(1, 1'b0, '0, 0, 0, 1'b0);
    check("T5_literal", last_out, {4{16'h0100}});

    // T6: round half up at the boundary
    fill_const(1, 16'h0001, {16'h0000, 16'h0000, 16'hFF80, 16'h0080});
    run_kernel(1, 1'b0, '0, 0, 0, 1'b0);
    check("T6_literal", last_out, {16'h0000, 16'h0000, 16'h0000, 16'h0001});

    // Randomized kernels
    for (int t = 0; t < 30; t++) begin
      int len;
      len = $urandom_range(0, 16);
      for (int b = 0; b < 16; b++) begin
        beat_data[b] = ($urandom_range(0, 3) == 0) ? DATA_W'($urandom)
                                                   : DATA_W'($urandom_range(0, 1023) - 512);
        for (int l = 0; l < LANES; l++)
          beat_w[b][l] = ($urandom_range(0, 3) == 0) ? DATA_W'($urandom)
                                                     : DATA_W'($urandom_range(0, 1023) - 512);
      end
      run_kernel(len, 1'($urandom_range(0, 1)), {$urandom, $urandom}, 2,
                 $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
